instr_fetch: RTL and testbench

Fetch stage that sits directly upstream of imm_gen and the decoder. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. It presents each fetched 32-bit instruction with its PC to decode over a valid/ready handshake. It takes the 12-bit SB-type immediate that imm_gen produces and the branch decision, and computes the next PC.

---
 rtl/instr_fetch.sv | 113 +++++++++++
 tb/tb_instr_fetch.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads words from instruction memory over a
// req/ack handshake and hands each instruction plus its PC to decode over valid/ready.
module instr_fetch #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [11:0] branch_imm,
  output logic        misalign_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] ERROR = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic [31:0] branch_off;
  logic [31:0] next_pc;
  logic        consume;

  // SB-type immediate encodes imm[12:1]; bit 0 is implicitly zero.
  assign branch_off = {{19{branch_imm[11]}}, branch_imm, 1'b0};
  assign next_pc    = branch_taken ? (pc_q + branch_off) : (pc_q + 32'd4);
  assign consume    = valid_q & instr_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    req_d   = req_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        req_d   = 1'b1;
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (consume) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            req_d   = 1'b1;
            state_d = FETCH;
          end else begin
            err_d   = 1'b1;
            state_d = ERROR;
          end
        end
      end
      ERROR: begin
        req_d = 1'b0;
      end
      default: begin
        state_d = ERROR;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      instr_q <= NOP_INSTR;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // The fetch address always tracks the PC, so it is stable for the whole request.
  assign imem_addr    = pc_q;
  assign imem_req     = req_q;
  assign instr        = instr_q;
  assign pc           = pc_q;
  assign instr_valid  = valid_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: randomized memory latency, decode stalls and
// branches checked against a PC-sequence model, plus directed boundary scenarios.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_ack = 1'b0, ack2 = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_ready = 1'b0, ready2 = 1'b0;
  logic        branch_taken = 1'b0;
  logic [11:0] branch_imm = '0;

  logic        imem_req, instr_valid, misalign_err;
  logic [31:0] imem_addr, instr, pc;
  logic        req2, valid2, err2;
  logic [31:0] addr2, instr2, pc2;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_instr = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .pc(pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .branch_taken(branch_taken),
    .branch_imm(branch_imm), .misalign_err(misalign_err)
  );

  instr_fetch #(.PC_RESET(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(imem_rdata), .instr(instr2), .pc(pc2),
    .instr_valid(valid2), .instr_ready(ready2), .branch_taken(branch_taken),
    .branch_imm(branch_imm), .misalign_err(err2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; imem_ack = 1'b0; ack2 = 1'b0; instr_ready = 1'b0; ready2 = 1'b0;
    branch_taken = 1'b0; branch_imm = '0;
    #2;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign_err !== 1'b0 || pc !== 32'h0 ||
        imem_addr !== 32'h0 || instr !== NOP) begin
      failures++;
      $display("FAIL reset: req=%b valid=%b err=%b pc=%h addr=%h instr=%h want 0 0 0 0 0 %h",
               imem_req, instr_valid, misalign_err, pc, imem_addr, instr, NOP);
    end
    tick();
    rst_n = 1'b1;
    exp_pc = 32'h0;
  endtask

  task automatic fetch_one(input int wait_n, input logic [31:0] data);
    int i = 0;
    while (imem_req !== 1'b1 && i < 20) begin
      tick();
      i++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      failures++;
      $display("FAIL req_timeout: req=%b want 1", imem_req);
      return;
    end
    checks++;
    if (imem_addr !== exp_pc || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL req_addr: addr=%h valid=%b want %h 0", imem_addr, instr_valid, exp_pc);
    end
    repeat (wait_n) begin
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL ack_wait: req=%b addr=%h valid=%b want 1 %h 0",
                 imem_req, imem_addr, instr_valid, exp_pc);
      end
    end
    imem_ack = 1'b1; imem_rdata = data;
    tick();
    imem_ack = 1'b0; imem_rdata = $urandom;
    exp_instr = data;
    checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== data || pc !== exp_pc) begin
      failures++;
      $display("FAIL capture: valid=%b req=%b instr=%h pc=%h want 1 0 %h %h",
               instr_valid, imem_req, instr, pc, data, exp_pc);
    end
  endtask

  task automatic consume(input int delay, input logic br, input logic [11:0] imm,
                         input logic noise);
    int          off;
    logic [31:0] nxt;
    repeat (delay) begin
      instr_ready = 1'b0; branch_taken = 1'($urandom_range(0, 1));
      branch_imm = 12'($urandom); imem_ack = noise; imem_rdata = $urandom;
      tick();
      imem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== exp_instr || pc !== exp_pc) begin
        failures++;
        $display("FAIL hold_stable: valid=%b req=%b instr=%h pc=%h want 1 0 %h %h",
                 instr_valid, imem_req, instr, pc, exp_instr, exp_pc);
      end
    end
    instr_ready = 1'b1; branch_taken = br; branch_imm = imm;
    tick();
    instr_ready = 1'b0; branch_taken = 1'b0;
    // Byte offset of the 13-bit two's-complement target displacement.
    if (br) off = imm[11] ? int'({imm, 1'b0}) - 8192 : int'({imm, 1'b0});
    else off = 4;
    nxt = exp_pc + 32'(off);
    checks++;
    if (nxt[1:0] != 2'b00) begin
      if (misalign_err !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0 ||
          instr !== NOP || pc !== exp_pc) begin
        failures++;
        $display("FAIL misalign: err=%b valid=%b req=%b instr=%h pc=%h want 1 0 0 %h %h",
                 misalign_err, instr_valid, imem_req, instr, pc, NOP, exp_pc);
      end
    end else begin
      exp_pc = nxt;
      if (misalign_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== nxt || pc !== nxt ||
          instr_valid !== 1'b0 || instr !== NOP) begin
        failures++;
        $display("FAIL next_pc: err=%b req=%b addr=%h pc=%h valid=%b instr=%h want 0 1 %h %h 0 %h",
                 misalign_err, imem_req, imem_addr, pc, instr_valid, instr, nxt, nxt, NOP);
      end
    end
  endtask

  task automatic test_sequential;
    int c0;
    test_reset();
    fetch_one(0, 32'h0070_0013);
    consume(0, 1'b0, 12'h0, 1'b0);
    c0 = cyc;
    fetch_one(0, $urandom);
    consume(0, 1'b0, 12'h0, 1'b0);
    fetch_one(0, $urandom);
    consume(0, 1'b0, 12'h0, 1'b0);
    checks++;
    if (cyc - c0 != 4 || imem_addr !== 32'hC) begin
      failures++;
      $display("FAIL throughput: cycles=%0d addr=%h want 4 0000000c", cyc - c0, imem_addr);
    end
  endtask

  task automatic test_stall;
    fetch_one(3, $urandom);
    consume(4, 1'b0, 12'h0, 1'b1);
  endtask

  task automatic test_branch;
    test_reset();
    fetch_one(0, $urandom); consume(0, 1'b1, 12'd128, 1'b0);
    fetch_one(0, $urandom); consume(0, 1'b1, 12'd16, 1'b0);
    checks++;
    if (imem_addr !== 32'h120) begin
      failures++; $display("FAIL branch_fwd: addr=%h want 00000120", imem_addr);
    end
    fetch_one(0, $urandom); consume(0, 1'b1, 12'hFF0, 1'b0);
    fetch_one(0, $urandom); consume(0, 1'b1, 12'hFFE, 1'b0);
    checks++;
    if (imem_addr !== 32'h0FC) begin
      failures++; $display("FAIL branch_back: addr=%h want 000000fc", imem_addr);
    end
    fetch_one(0, $urandom); consume(0, 1'b0, 12'h0, 1'b0);
    fetch_one(0, $urandom); consume(0, 1'b1, 12'h800, 1'b0);
    checks++;
    if (imem_addr !== 32'hFFFF_F100) begin
      failures++; $display("FAIL branch_wrap: addr=%h want fffff100", imem_addr);
    end
  endtask

  task automatic test_misalign;
    fetch_one(1, $urandom);
    consume(0, 1'b1, 12'd1, 1'b0);
    repeat (8) begin
      imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom; instr_ready = 1'b1;
      tick();
      checks++;
      if (misalign_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== NOP) begin
        failures++;
        $display("FAIL error_absorb: err=%b req=%b valid=%b instr=%h want 1 0 0 %h",
                 misalign_err, imem_req, instr_valid, instr, NOP);
      end
    end
    imem_ack = 1'b0; instr_ready = 1'b0;
    test_reset();
    fetch_one(0, $urandom);
    consume(0, 1'b0, 12'h0, 1'b0);
  endtask

  task automatic test_wrap;
    int i = 0;
    test_reset();
    while (req2 !== 1'b1 && i < 20) begin
      tick();
      i++;
    end
    checks++;
    if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_first: req=%b addr=%h want 1 fffffffc", req2, addr2);
    end
    ack2 = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    ack2 = 1'b0;
    checks++;
    if (valid2 !== 1'b1 || instr2 !== 32'h1234_5678 || pc2 !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_capture: valid=%b instr=%h pc=%h want 1 12345678 fffffffc",
               valid2, instr2, pc2);
    end
    ready2 = 1'b1; branch_taken = 1'b0;
    tick();
    ready2 = 1'b0;
    checks++;
    if (req2 !== 1'b1 || addr2 !== 32'h0 || err2 !== 1'b0 || pc2 !== 32'h0) begin
      failures++;
      $display("FAIL wrap_next: req=%b addr=%h err=%b pc=%h want 1 0 0 0", req2, addr2, err2, pc2);
    end
  endtask

  task automatic test_reset_abort;
    test_reset();
    fetch_one(0, $urandom);
    consume(0, 1'b0, 12'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pc !== 32'h0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_fetch: req=%b addr=%h pc=%h valid=%b want 0 0 0 0",
               imem_req, imem_addr, pc, instr_valid);
    end
    tick();
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = $urandom;
    tick();
    imem_ack = 1'b0;
    exp_pc = 32'h0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0 || instr !== NOP) begin
      failures++;
      $display("FAIL stale_ack: valid=%b req=%b addr=%h instr=%h want 0 1 0 %h",
               instr_valid, imem_req, imem_addr, instr, NOP);
    end
    fetch_one(2, $urandom);
    rst_n = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || instr !== NOP || pc !== 32'h0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL abort_hold: valid=%b instr=%h pc=%h req=%b want 0 %h 0 0",
               instr_valid, instr, pc, imem_req, NOP);
    end
    tick();
    rst_n = 1'b1;
    exp_pc = 32'h0;
    fetch_one(0, $urandom);
    consume(1, 1'b0, 12'h0, 1'b0);
  endtask

  task automatic test_random;
    test_reset();
    for (int n = 0; n < 40; n++) begin
      fetch_one($urandom_range(0, 3), $urandom);
      consume($urandom_range(0, 3), 1'($urandom_range(0, 1)), {11'($urandom), 1'b0},
              1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_misalign();
    test_wrap();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
